// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment feeder: hex or double-dabble decimal load,
// free-running digit scan with leading-zero blanking.
module seven_segment_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BIN_W       = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_valid,
  output logic              io_ready,
  input  logic [BIN_W-1:0]  io_value,
  input  logic              io_hexMode,
  input  logic              io_blankLeading,
  output logic [3:0]        io_digit,
  output logic [DIGITS-1:0] io_anode,
  output logic              io_blank,
  output logic              io_overflow
);

  localparam int DW = 4 * DIGITS;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic longint unsigned pow10m1(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r - 1;
  endfunction

  localparam longint unsigned DEC_MAX = pow10m1(DIGITS);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    disp_q, disp_d;
  logic [DW-1:0]    bcd_q, bcd_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             blank_en_q, blank_en_d;
  logic             blank_pend_q, blank_pend_d;
  logic             ovf_q, ovf_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [DW-1:0]    hex_load;
  logic [DW-2:0]    bcd_adj;
  logic [DW-1:0]    bcd_next;
  logic [3:0]       top_nib;
  logic             all_zero;

  if (BIN_W >= DW) begin : g_trunc
    assign hex_load = io_value[DW-1:0];
  end else begin : g_ext
    assign hex_load = {{(DW - BIN_W){1'b0}}, io_value};
  end

  // Top digit keeps only 3 bits: its MSB is shifted out and dropped.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    top_nib = bcd_q[DW-1 -: 4];
    bcd_adj[DW-2 -: 3] = top_nib[2:0]
                       + ((top_nib >= 4'd5) ? 3'd3 : 3'd0);
    bcd_next = {bcd_adj, shift_q[BIN_W-1]};
  end

  always_comb begin
    state_d      = state_q;
    disp_d       = disp_q;
    bcd_d        = bcd_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    blank_en_d   = blank_en_q;
    blank_pend_d = blank_pend_q;
    ovf_d        = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io_valid) begin
          if (io_hexMode) begin
            disp_d     = hex_load;
            ovf_d      = 1'b0;
            blank_en_d = io_blankLeading;
          end else begin
            state_d      = CONVERT;
            shift_d      = io_value;
            bcd_d        = '0;
            cnt_d        = CW'(BIN_W);
            ovf_d        = 64'(io_value) > DEC_MAX;
            blank_pend_d = io_blankLeading;
          end
        end
      end
      CONVERT: begin
        bcd_d   = bcd_next;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          disp_d     = bcd_next;
          blank_en_d = blank_pend_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      disp_q       <= '0;
      bcd_q        <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      blank_en_q   <= 1'b0;
      blank_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      disp_q       <= disp_d;
      bcd_q        <= bcd_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      blank_en_q   <= blank_en_d;
      blank_pend_q <= blank_pend_d;
      ovf_q        <= ovf_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin
    io_anode = '0;
    io_digit = '0;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(idx_q) == i) begin
        io_anode[i] = 1'b1;
        io_digit    = disp_q[4*i +: 4];
      end
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0)
        all_zero = 1'b0;
    end
  end

  assign io_blank    = blank_en_q && (idx_q != '0) && all_zero;
  assign io_ready    = (state_q == IDLE);
  assign io_overflow = ovf_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Randomized bench for seven_segment_scan_driver against an
// arithmetic model of the display contents and scan position.
module tb_seven_segment_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;
  localparam int BIN_W  = 14;

  logic              clock = 0;
  logic              reset = 1;
  logic              io_valid = 0;
  logic              io_ready;
  logic [BIN_W-1:0]  io_value = '0;
  logic              io_hexMode = 0;
  logic              io_blankLeading = 0;
  logic [3:0]        io_digit;
  logic [DIGITS-1:0] io_anode;
  logic              io_blank;
  logic              io_overflow;

  int checks = 0;
  int errors = 0;

  int exp_disp = 0;
  bit exp_ben  = 0;
  bit exp_ovf  = 0;
  int mcyc     = 0;

  seven_segment_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .BIN_W(BIN_W)
  ) dut (
    .clock(clock), .reset(reset),
    .io_valid(io_valid), .io_ready(io_ready),
    .io_value(io_value), .io_hexMode(io_hexMode),
    .io_blankLeading(io_blankLeading),
    .io_digit(io_digit), .io_anode(io_anode),
    .io_blank(io_blank), .io_overflow(io_overflow)
  );

  always #5 clock = ~clock;

  always @(posedge clock or posedge reset)
    if (reset) mcyc <= 0;
    else mcyc <= mcyc + 1;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_idx();
    return (mcyc / RDIV) % DIGITS;
  endfunction

  function automatic int nib(input int v, input int i);
    return (v >> (4 * i)) & 15;
  endfunction

  function automatic int to_bcd(input int v);
    int r, m;
    r = 0;
    m = v % 10000;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | ((m % 10) << (4 * i));
      m = m / 10;
    end
    return r;
  endfunction

  task automatic scan_check(input int n);
    int ix;
    bit bl;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      ix = exp_idx();
      bl = exp_ben && ix > 0 && ((exp_disp >> (4 * ix)) == 0);
      chk("anode", io_anode, 1 << ix);
      chk("digit", io_digit, nib(exp_disp, ix));
      chk("blank", io_blank, bl);
      chk("ready", io_ready, 1);
      chk("ovf", io_overflow, exp_ovf);
    end
  endtask

  task automatic load(input int v, input bit hex, input bit bl,
                      input bit poke);
    @(negedge clock);
    chk("rdy_pre", io_ready, 1);
    io_valid        = 1;
    io_value        = v[BIN_W-1:0];
    io_hexMode      = hex;
    io_blankLeading = bl;
    @(posedge clock);
    #1 io_valid = 0;
    if (!hex) begin
      for (int i = 0; i < BIN_W; i++) begin
        @(negedge clock);
        chk("busy", io_ready, 0);
        chk("hold", io_digit, nib(exp_disp, exp_idx()));
        if (poke && i == 3) begin
          io_valid   = 1;
          io_value   = 14'd5555;
          io_hexMode = 1;
        end else begin
          io_valid = 0;
        end
      end
      io_valid = 0;
      exp_disp = to_bcd(v);
      exp_ovf  = v > 9999;
    end else begin
      exp_disp = v & 16'hFFFF;
      exp_ovf  = 0;
    end
    exp_ben = bl;
    @(negedge clock);
    chk("rdy_post", io_ready, 1);
    chk("ovf_post", io_overflow, exp_ovf);
    chk("val", io_digit, nib(exp_disp, exp_idx()));
  endtask

  initial begin
    reset = 1;
    repeat (20) @(negedge clock);
    chk("rst_ready", io_ready, 1);
    chk("rst_digit", io_digit, 0);
    chk("rst_blank", io_blank, 0);
    chk("rst_ovf", io_overflow, 0);
    chk("rst_anode", io_anode, 1);
    reset = 0;
    scan_check(20);

    load(1234, 0, 0, 0);
    scan_check(16);
    load(12'h0A5, 1, 1, 0);
    scan_check(16);
    load(12345, 0, 0, 0);
    scan_check(16);
    load(9999, 0, 0, 0);
    scan_check(16);
    load(0, 0, 1, 0);
    scan_check(16);
    load(4321, 0, 1, 1);
    scan_check(16);

    for (int k = 0; k < 25; k++) begin
      load(int'($urandom_range(0, 16383)), 1'($urandom),
           1'($urandom), 1'($urandom));
      scan_check(int'($urandom_range(1, 17)));
    end
    load(10000, 0, 1, 0);
    scan_check(16);
    load(7, 1, 1, 0);
    scan_check(16);

    load(5000, 1, 0, 0);
    @(negedge clock);
    io_valid   = 1;
    io_value   = 14'd4321;
    io_hexMode = 0;
    @(posedge clock);
    #1 io_valid = 0;
    repeat (7) @(negedge clock);
    chk("mid_busy", io_ready, 0);
    reset = 1;
    #1;
    chk("abort_ready", io_ready, 1);
    chk("abort_anode", io_anode, 1);
    chk("abort_digit", io_digit, 0);
    chk("abort_ovf", io_overflow, 0);
    chk("abort_blank", io_blank, 0);
    exp_disp = 0;
    exp_ben  = 0;
    exp_ovf  = 0;
    repeat (3) @(negedge clock);
    reset = 0;
    scan_check(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
